// File: rtl/data_mem_responder_pkg.sv
// Shared types and sizing constants for the data memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned DEF_DEPTH   = 64;
  localparam int unsigned DEF_LATENCY = 2;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous byte-enable write, combinational read.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wen,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              idx_ok;

  assign idx_ok = ({{(32-AW){1'b0}}, idx} < DEPTH);

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (wen && idx_ok && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (idx_ok) begin
      rdata = mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with programmable wait states and range check.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic              clock,
  input  logic              start,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [2:0]        cnt;
  logic              cap_we;
  logic [29:0]       cap_idx;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              in_range;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign in_range         = ({2'b00, cap_idx} < DEPTH);
  assign mem_wen          = (state == RESP) && cap_we && in_range;

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .wen   (mem_wen),
    .idx   (cap_idx[AW-1:0]),
    .wdata (cap_wdata),
    .be    (cap_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_idx   <= addr[31:2];
            cap_wdata <= wdata;
            cap_be    <= be;
            cnt       <= 3'(LATENCY);
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are registered out of RESP, so the strobe lands LATENCY+1 edges after
  // the sampling edge and coincides with the IDLE cycle that may accept the next req.
  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= (state == RESP);
      err   <= (state == RESP) && !in_range;
      rdata <= ((state == RESP) && !cap_we && in_range) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, reset/back-to-back sequences, random ops vs. array model.
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;

  logic        clock = 1'b0;
  logic        start;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  int checks = 0;
  int passed = 0;

  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [11];

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clock (clock),
    .start (start),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .rdata (rdata),
    .ack   (ack),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issues one transaction; lat counts edges from the sampling edge to the one raising ack.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e,
                     output int lat);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    rd = '0; e = 1'b0;
    @(posedge clock); #1;
    we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = 0;
    while (!ack && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    if (ack) begin
      rd = rdata;
      e  = err;
    end
    req = 1'b0;
    @(posedge clock); #1;
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          t [2];
    logic [31:0] r [2];
    int          n;
    int          cyc;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEAA, 1'b0};
    vt[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'h0, 1'b1};
    vt[6]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 32'h0, 1'b1};
    vt[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0};
    vt[8]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 32'h0000_0013, 32'h0,         4'b0000, 32'hDEAD_BEAA, 1'b0};
    vt[10] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'b1111, 32'h0, 1'b0};

    start = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("reset_ack",   {31'b0, ack}, 32'd0);
      check("reset_err",   {31'b0, err}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
    end
    start = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn(vt[i].w, vt[i].a, vt[i].d, vt[i].b, rd, e, lat);
      check("vec_latency", 32'(lat), 32'(LAT + 1));
      check("vec_err", {31'b0, e}, {31'b0, vt[i].exp_err});
      if (!vt[i].w || vt[i].exp_err) check("vec_rdata", rd, vt[i].exp_rd);
    end

    // Reset while waiting on a write: the write must be dropped.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555_5555; be = 4'b1111;
    @(posedge clock); #1;
    req = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("midrst_ack", {31'b0, ack}, 32'd0);
    end
    start = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 4'b0, rd, e, lat);
    check("midrst_latency", 32'(lat), 32'(LAT + 1));
    check("midrst_rdata", rd, 32'h1111_1111);

    // Back-to-back reads with req held; edge 1 is the first sampling edge.
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'b0;
    n = 0; cyc = 0; t[0] = 0; t[1] = 0; r[0] = '0; r[1] = '0;
    while (n < 2 && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
      if (ack) begin
        t[n] = cyc; r[n] = rdata; n++;
      end
    end
    req = 1'b0;
    check("b2b_count", 32'(n), 32'd2);
    check("b2b_first", 32'(t[0]), 32'(LAT + 2));
    check("b2b_gap", 32'(t[1] - t[0]), 32'(LAT + 2));
    check("b2b_rdata0", r[0], 32'hDEAD_BEAA);
    check("b2b_rdata1", r[1], 32'hDEAD_BEAA);
    @(posedge clock); #1;
    check("b2b_idle", {31'b0, ack}, 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      txn(1'b1, 32'(i) << 2, ref_mem[i], 4'b1111, rd, e, lat);
      check("init_err", {31'b0, e}, 32'd0);
    end

    for (int k = 0; k < 150; k++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] word;
      logic        oor;
      w = 1'($urandom);
      d = $urandom;
      b = 4'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h8000_0000;
      else a = ($urandom_range(0, DEPTH + 7) << 2) | $urandom_range(0, 3);
      oor = (a / 4) >= DEPTH;
      txn(w, a, d, b, rd, e, lat);
      check("rnd_latency", 32'(lat), 32'(LAT + 1));
      check("rnd_err", {31'b0, e}, {31'b0, oor});
      if (oor) begin
        check("rnd_oor_rdata", rd, 32'd0);
      end else if (!w) begin
        check("rnd_rdata", rd, ref_mem[a / 4]);
      end else begin
        word = ref_mem[a / 4];
        for (int j = 0; j < 4; j++) if (b[j]) word[8*j +: 8] = d[8*j +: 8];
        ref_mem[a / 4] = word;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, legal range 0..7: number of wait cycles inserted before the acknowledge.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port start, input, 1 bit: asynchronous active-low reset; low holds the block in reset, high lets it run.
REQ-005 Port req, input, 1 bit: initiator requests an access.
REQ-006 Port we, input, 1 bit: 1 selects a write, 0 selects a read.
REQ-007 Port addr, input, 32 bits: byte address; word index is addr[31:2], and addr[1:0] is ignored.
REQ-008 Port wdata, input, 32 bits: write data.
REQ-009 Port be, input, 4 bits: byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 Port rdata, output, 32 bits: read data, valid only while ack=1.
REQ-011 Port ack, output, 1 bit: one-cycle completion strobe.
REQ-012 Port err, output, 1 bit: error flag, valid only while ack=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, the block SHALL capture addr, we, wdata and be. It SHALL go to RESP if LATENCY=0, otherwise to WAIT with the counter loaded with LATENCY.
REQ-015 In WAIT, the counter SHALL decrement each cycle, and the block SHALL go to RESP on the cycle the counter equals 1.
REQ-016 In RESP, ack SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-017 ack SHALL rise LATENCY+1 cycles after the clock edge that samples req in IDLE.
REQ-018 During WAIT and RESP, changes on req, addr, we, wdata and be SHALL be ignored, because the captured values are used.
REQ-019 The initiator holds req until ack. If req is still 1 in the IDLE cycle after RESP, it SHALL be accepted as a new transaction, giving a back-to-back period of LATENCY+2 cycles.
REQ-020 A read SHALL drive rdata with mem[index] in the RESP cycle. rdata SHALL be 0 in every non-RESP cycle.
REQ-021 A write SHALL update only the enabled bytes of mem[index] at the end of the RESP cycle. With be=0000, memory SHALL be unchanged and ack SHALL be normal.
REQ-022 If index >= DEPTH, the block SHALL set err=1 with ack, rdata=0, and SHALL leave memory unchanged. Otherwise err SHALL be 0.
REQ-023 A read issued after a write completes SHALL return the written data, so there is no read-after-write hazard.

Reset
REQ-024 Whenever start=0, without waiting for clock, the block SHALL force: state IDLE, counter 0, ack 0, err 0, rdata 0, and captured request registers 0.
REQ-025 Reset asserted during WAIT or RESP SHALL abandon the transaction: no ack is produced and a pending write is not performed.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 The first request SHALL be sampled on the first rising clock edge after start goes high.

Structure
REQ-028 A shared package SHALL hold the following items:
- the state enum (IDLE, WAIT, RESP);
- the word width (32) and byte-enable width (4);
- the default DEPTH and LATENCY values.
REQ-029 The storage SHALL be one sub-module, data_mem_array. It has a synchronous byte-enable write port and a combinational read port indexed by the word index. The FSM, counter and error check remain in data_mem_responder.

Verification (LATENCY=2, DEPTH=64)
REQ-030 Reset: hold start=0 and toggle clock -> ack=0, err=0 and rdata=0 throughout.
REQ-031 Write then read:
- Stimulus: write 0xDEADBEEF to addr 0x10 with be=1111, then read addr 0x10.
- Response: each ack rises exactly 3 cycles after req is sampled, and the read gives rdata=0xDEADBEEF with err=0.
REQ-032 Partial write:
- Stimulus: write 0x000000AA to addr 0x10 with be=0001, then read addr 0x10.
- Response: rdata=0xDEADBEAA.
REQ-033 Out of range:
- Stimulus: read addr 0x100 (index 64), then write 0x12345678 there.
- Response: both acks carry err=1 and rdata=0; a read of addr 0x0 is unchanged.
REQ-034 Reset mid-write:
- Stimulus: write 0x55555555 to addr 0x20 (prior value 0x11111111), then pull start low in WAIT.
- Response: no ack; after start returns high, a read of 0x20 returns 0x11111111.
REQ-035 Back-to-back: hold req=1 for two reads at 0x10 -> two acks exactly 4 cycles apart, both with rdata=0xDEADBEAA.
